// File: rtl/piso_pkg.sv
// Shared definitions for the piso_reg parallel-in serial-out shifter.
// Holds the default word size and the counter width helper.
package piso_pkg;

    localparam int PISO_DEFAULT_SIZE = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_reg.sv
// Continuous back-to-back parallel-in serial-out shift register, MSB first.
// Define PISO_LSB_FIRST_EN to emit each word LSB first instead.
module piso_reg
    import piso_pkg::*;
#(
    parameter int SIZE = PISO_DEFAULT_SIZE
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic [SIZE-1:0] data_in,
    output logic            r_data_out
);

    localparam int CW = clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    logic [SIZE-1:0] word_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   sel;
    logic            boundary;
    logic            first_bit;

`ifdef PISO_LSB_FIRST_EN
    assign sel       = cnt_q;
    assign first_bit = data_in[0];
`else
    assign sel       = LAST - cnt_q;
    assign first_bit = data_in[SIZE-1];
`endif

    // Unreachable counter codes restart the word rather than lock up.
    if ((1 << CW) == SIZE) begin : g_pow2
        assign boundary = (cnt_q == '0);
    end else begin : g_npow2
        assign boundary = (cnt_q == '0) || (cnt_q > LAST);
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            word_q     <= '0;
            cnt_q      <= '0;
            r_data_out <= 1'b0;
        end else if (boundary) begin
            word_q     <= data_in;
            r_data_out <= first_bit;
            cnt_q      <= CW'(1);
        end else begin
            r_data_out <= word_q[sel];
            cnt_q      <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_piso_reg.sv
// Randomized self-checking bench for piso_reg (SIZE=8 and SIZE=5).
// Reference model is a per-instance queue of bits still to be sent.
module tb_piso_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] d8  = '0;
    logic [4:0] d5  = '0;
    logic       q8;
    logic       q5;

    int n_checks = 0;
    int n_fail   = 0;

    logic pend8[$];
    logic pend5[$];

    piso_reg #(.SIZE(8)) dut8 (
        .clk_in    (clk),
        .reset_in  (rst),
        .data_in   (d8),
        .r_data_out(q8)
    );

    piso_reg #(.SIZE(5)) dut5 (
        .clk_in    (clk),
        .reset_in  (rst),
        .data_in   (d5),
        .r_data_out(q5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got,
                         input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    // Queue the bits of a word in transmit order.
    task automatic load8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
`ifdef PISO_LSB_FIRST_EN
            pend8.push_back(w[i]);
`else
            pend8.push_back(w[7-i]);
`endif
        end
    endtask

    task automatic load5(input logic [4:0] w);
        for (int i = 0; i < 5; i++) begin
`ifdef PISO_LSB_FIRST_EN
            pend5.push_back(w[i]);
`else
            pend5.push_back(w[4-i]);
`endif
        end
    endtask

    task automatic tick(input string tag);
        logic e8;
        logic e5;
        if (pend8.size() == 0) load8(d8);
        if (pend5.size() == 0) load5(d5);
        e8 = pend8.pop_front();
        e5 = pend5.pop_front();
        @(posedge clk);
        #1;
        check({tag, "_s8"}, q8, e8);
        check({tag, "_s5"}, q5, e5);
    endtask

    task automatic reset_for(input int n, input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_imm8"}, q8, 1'b0);
        check({tag, "_imm5"}, q5, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold8"}, q8, 1'b0);
            check({tag, "_hold5"}, q5, 1'b0);
        end
        pend8.delete();
        pend5.delete();
        rst = 1'b0;
    endtask

    initial begin
        #2;
        d8 = 8'b10101100;
        d5 = 5'b10011;
        reset_for(30, "rst");

        for (int i = 0; i < 8; i++) tick("single");
        tick("s5_9");
        tick("s5_10");
        for (int i = 0; i < 6; i++) tick("align");

        d8 = 8'hA5;
        tick("b2b_a5");
        d8 = 8'h3C;
        for (int i = 0; i < 15; i++) tick("b2b");

        d8 = 8'hF0;
        for (int i = 0; i < 3; i++) tick("pre_mid");
        #2;
        reset_for(2, "midrst");
        d8 = 8'h81;
        for (int i = 0; i < 8; i++) tick("post_mid");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) d8 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d5 = 5'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                reset_for($urandom_range(0, 2), "rnd_rst");
            end
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
